// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM of the multicycle RV32I core; sequences the shared ALU,
// the unified memory port and the register file, with a bounded wait on memory ready.
module multicycle_controller #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] i_op,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic       o_mem_req,
    output logic       o_mem_write,
    output logic       o_adr_src,
    output logic       o_ir_write,
    output logic       o_pc_write,
    output logic       o_reg_write,
    output logic [1:0] o_result_src,
    output logic [1:0] o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [2:0] o_alu_control,
    output logic [1:0] o_imm_src,
    output logic       o_instr_done,
    output logic       o_halted,
    output logic       o_bus_error
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECUTER,
        S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL, S_JALR, S_JALR_LINK, S_HALT
    } state_t;

    localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_wait;
    logic          r_bus_error;
    logic          w_waiting;
    logic          w_timeout;
    logic [2:0]    w_decode_alu;
    logic          w_unused;

    assign w_unused = ^{i_funct7[6], i_funct7[4:0]};
    assign w_waiting = (r_state == S_FETCH || r_state == S_MEMREAD || r_state == S_MEMWRITE) && !i_mem_ready;
    assign w_timeout = (TIMEOUT_CYCLES > 0) && w_waiting && (r_wait == CW'(TIMEOUT_CYCLES - 1));
    assign o_bus_error = r_bus_error;

    // funct7[5] only selects sub for register-register ops; addi ignores it
    assign w_decode_alu = (i_funct3 == 3'b000) ? ((i_op[5] & i_funct7[5]) ? 3'b001 : 3'b000) :
                          (i_funct3 == 3'b010) ? 3'b101 :
                          (i_funct3 == 3'b110) ? 3'b011 :
                          (i_funct3 == 3'b111) ? 3'b010 : 3'b000;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:     w_next = i_mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:
                case (i_op)
                    7'b0000011, 7'b0100011: w_next = S_MEMADR;
                    7'b0110011:             w_next = S_EXECUTER;
                    7'b0010011:             w_next = S_EXECUTEI;
                    7'b1100011:             w_next = S_BEQ;
                    7'b1101111:             w_next = S_JAL;
                    7'b1100111:             w_next = S_JALR;
                    default:                w_next = S_HALT;
                endcase
            S_MEMADR:    w_next = i_op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:   w_next = i_mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:     w_next = S_FETCH;
            S_MEMWRITE:  w_next = i_mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER:  w_next = S_ALUWB;
            S_EXECUTEI:  w_next = S_ALUWB;
            S_ALUWB:     w_next = S_FETCH;
            S_BEQ:       w_next = S_FETCH;
            S_JAL:       w_next = S_ALUWB;
            S_JALR:      w_next = S_JALR_LINK;
            S_JALR_LINK: w_next = S_ALUWB;
            default:     w_next = S_HALT;
        endcase
        if (w_timeout)
            w_next = S_HALT;
    end

    // Outputs are combinational so ready-qualified strobes act in the completing cycle
    always_comb begin
        o_mem_req     = 1'b0;
        o_mem_write   = 1'b0;
        o_adr_src     = 1'b0;
        o_ir_write    = 1'b0;
        o_pc_write    = 1'b0;
        o_reg_write   = 1'b0;
        o_result_src  = 2'b00;
        o_alu_src_a   = 2'b00;
        o_alu_src_b   = 2'b00;
        o_alu_control = 3'b000;
        o_imm_src     = 2'b00;
        o_instr_done  = 1'b0;
        o_halted      = 1'b0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    o_mem_req    = 1'b1;
                    o_alu_src_b  = 2'b10;
                    o_result_src = 2'b10;
                    o_ir_write   = i_mem_ready;
                    o_pc_write   = i_mem_ready;
                end
                S_DECODE: begin
                    o_alu_src_a = 2'b01;
                    o_alu_src_b = 2'b01;
                    o_imm_src   = (i_op == 7'b0100011) ? 2'b01 :
                                  (i_op == 7'b1100011) ? 2'b10 :
                                  (i_op == 7'b1101111) ? 2'b11 : 2'b00;
                end
                S_MEMADR: begin
                    o_alu_src_a = 2'b10;
                    o_alu_src_b = 2'b01;
                    o_imm_src   = (i_op == 7'b0100011) ? 2'b01 : 2'b00;
                end
                S_MEMREAD: begin
                    o_mem_req = 1'b1;
                    o_adr_src = 1'b1;
                end
                S_MEMWB: begin
                    o_result_src = 2'b01;
                    o_reg_write  = 1'b1;
                    o_instr_done = 1'b1;
                end
                S_MEMWRITE: begin
                    o_mem_req    = 1'b1;
                    o_mem_write  = 1'b1;
                    o_adr_src    = 1'b1;
                    o_instr_done = i_mem_ready;
                end
                S_EXECUTER: begin
                    o_alu_src_a   = 2'b10;
                    o_alu_control = w_decode_alu;
                end
                S_EXECUTEI: begin
                    o_alu_src_a   = 2'b10;
                    o_alu_src_b   = 2'b01;
                    o_alu_control = w_decode_alu;
                end
                S_ALUWB: begin
                    o_reg_write  = 1'b1;
                    o_instr_done = 1'b1;
                end
                S_BEQ: begin
                    o_alu_src_a   = 2'b10;
                    o_alu_control = 3'b001;
                    o_pc_write    = i_zero;
                    o_instr_done  = 1'b1;
                end
                S_JAL: begin
                    o_alu_src_a = 2'b01;
                    o_alu_src_b = 2'b10;
                    o_pc_write  = 1'b1;
                end
                S_JALR: begin
                    o_alu_src_a  = 2'b10;
                    o_alu_src_b  = 2'b01;
                    o_result_src = 2'b10;
                    o_pc_write   = 1'b1;
                end
                S_JALR_LINK: begin
                    o_alu_src_a = 2'b01;
                    o_alu_src_b = 2'b10;
                end
                S_HALT:  o_halted = 1'b1;
                default: o_halted = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_FETCH;
            r_wait      <= '0;
            r_bus_error <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wait  <= (w_next != r_state) ? '0 : r_wait + CW'(w_waiting);
            if (w_timeout)
                r_bus_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed instruction sequences checked cycle by cycle against
// a queue of expected control vectors built from an independent state-to-output model.
module tb_multicycle_controller;
    typedef enum int {
        T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE, T_EXECUTER,
        T_EXECUTEI, T_ALUWB, T_BEQ, T_JAL, T_JALR, T_JALR_LINK, T_HALT, T_RESET
    } st_t;

    typedef struct {
        string       tag;
        logic [19:0] v;
    } exp_t;

    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic [6:0] funct7 = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic       instr_done, halted, bus_error;
    logic       exp_berr = 1'b0;
    int         checks = 0;
    int         errors = 0;
    exp_t       sb[$];

    multicycle_controller #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .i_op(op), .i_funct3(funct3), .i_funct7(funct7),
        .i_zero(zero), .i_mem_ready(mem_ready), .o_mem_req(mem_req), .o_mem_write(mem_write),
        .o_adr_src(adr_src), .o_ir_write(ir_write), .o_pc_write(pc_write),
        .o_reg_write(reg_write), .o_result_src(result_src), .o_alu_src_a(alu_src_a),
        .o_alu_src_b(alu_src_b), .o_alu_control(alu_control), .o_imm_src(imm_src),
        .o_instr_done(instr_done), .o_halted(halted), .o_bus_error(bus_error)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] model(st_t st, logic rdy, logic z, logic berr);
        logic       mreq = 0, mw = 0, adr = 0, irw = 0, pcw = 0, rw = 0, done = 0, hlt = 0;
        logic [1:0] rs = 0, a = 0, b = 0, imm = 0;
        logic [2:0] alu = 0, dec;
        dec = (funct3 == 3'd0) ? ((op == OP_R && funct7[5]) ? 3'b001 : 3'b000) :
              (funct3 == 3'd2) ? 3'b101 : (funct3 == 3'd6) ? 3'b011 :
              (funct3 == 3'd7) ? 3'b010 : 3'b000;
        case (st)
            T_FETCH:     begin mreq = 1; b = 2; rs = 2; irw = rdy; pcw = rdy; end
            T_DECODE:    begin a = 1; b = 1; imm = (op == OP_SW) ? 2'd1 : (op == OP_BEQ) ? 2'd2 : (op == OP_JAL) ? 2'd3 : 2'd0; end
            T_MEMADR:    begin a = 2; b = 1; imm = (op == OP_SW) ? 2'd1 : 2'd0; end
            T_MEMREAD:   begin mreq = 1; adr = 1; end
            T_MEMWB:     begin rs = 1; rw = 1; done = 1; end
            T_MEMWRITE:  begin mreq = 1; mw = 1; adr = 1; done = rdy; end
            T_EXECUTER:  begin a = 2; alu = dec; end
            T_EXECUTEI:  begin a = 2; b = 1; alu = dec; end
            T_ALUWB:     begin rw = 1; done = 1; end
            T_BEQ:       begin a = 2; alu = 3'b001; pcw = z; done = 1; end
            T_JAL:       begin a = 1; b = 2; pcw = 1; end
            T_JALR:      begin a = 2; b = 1; rs = 2; pcw = 1; end
            T_JALR_LINK: begin a = 1; b = 2; end
            T_HALT:      hlt = 1;
            default:     hlt = 0;
        endcase
        return {mreq, mw, adr, irw, pcw, rw, rs, a, b, alu, imm, done, hlt, berr};
    endfunction

    function automatic logic [19:0] observed();
        return {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, result_src,
                alu_src_a, alu_src_b, alu_control, imm_src, instr_done, halted, bus_error};
    endfunction

    task automatic compare_front();
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (observed() === e.v)
        else begin
            errors++;
            $error("FAIL %s: observed %05h expected %05h", e.tag, observed(), e.v);
        end
    endtask

    task automatic step(string tag, st_t st, logic rdy, logic z = 1'b0);
        mem_ready = rdy;
        zero = z;
        sb.push_back('{tag, model(st, rdy, z, exp_berr)});
        @(negedge clk);
        compare_front();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(logic [6:0] o, logic [2:0] f3, logic [6:0] f7);
        op = o;
        funct3 = f3;
        funct7 = f7;
    endtask

    task automatic apply_reset(string tag);
        rst = 1'b1;
        exp_berr = 1'b0;
        #2;
        sb.push_back('{tag, model(T_RESET, 1'b0, 1'b0, 1'b0)});
        compare_front();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic alu_instr(string tag, logic [6:0] o, logic [2:0] f3, logic [6:0] f7);
        set_instr(o, f3, f7);
        step({tag, "_fetch"}, T_FETCH, 1'b1);
        step({tag, "_decode"}, T_DECODE, 1'b1);
        step({tag, "_exec"}, (o == OP_R) ? T_EXECUTER : T_EXECUTEI, 1'b1);
        step({tag, "_wb"}, T_ALUWB, 1'b1);
    endtask

    initial begin
        #2;
        apply_reset("reset");
        alu_instr("add", OP_R, 3'd0, 7'b0000000);
        alu_instr("sub", OP_R, 3'd0, 7'b0100000);
        alu_instr("slt", OP_R, 3'd2, 7'b0000000);
        alu_instr("or", OP_R, 3'd6, 7'b0000000);
        alu_instr("and", OP_R, 3'd7, 7'b0000000);
        alu_instr("addi", OP_I, 3'd0, 7'b0100000);
        set_instr(OP_LW, 3'd2, 7'd0);
        step("lw_fetch", T_FETCH, 1'b1);
        step("lw_decode", T_DECODE, 1'b0);
        step("lw_memadr", T_MEMADR, 1'b0);
        for (int i = 0; i < 3; i++)
            step("lw_memread_wait", T_MEMREAD, 1'b0);
        step("lw_memread_rdy", T_MEMREAD, 1'b1);
        step("lw_memwb", T_MEMWB, 1'b0);
        set_instr(OP_SW, 3'd2, 7'd0);
        step("sw_fetch", T_FETCH, 1'b1);
        step("sw_decode", T_DECODE, 1'b1);
        step("sw_memadr", T_MEMADR, 1'b1);
        step("sw_memwrite_wait", T_MEMWRITE, 1'b0);
        step("sw_memwrite_rdy", T_MEMWRITE, 1'b1);
        set_instr(OP_BEQ, 3'd0, 7'd0);
        step("beq_t_fetch", T_FETCH, 1'b1);
        step("beq_t_decode", T_DECODE, 1'b1);
        step("beq_taken", T_BEQ, 1'b1, 1'b1);
        step("beq_n_fetch", T_FETCH, 1'b1);
        step("beq_n_decode", T_DECODE, 1'b1);
        step("beq_not_taken", T_BEQ, 1'b1, 1'b0);
        set_instr(OP_JAL, 3'd0, 7'd0);
        step("jal_fetch", T_FETCH, 1'b1);
        step("jal_decode", T_DECODE, 1'b1);
        step("jal_jump", T_JAL, 1'b1);
        step("jal_wb", T_ALUWB, 1'b1);
        set_instr(OP_JALR, 3'd0, 7'd0);
        step("jalr_fetch", T_FETCH, 1'b1);
        step("jalr_decode", T_DECODE, 1'b1);
        step("jalr_jump", T_JALR, 1'b1);
        step("jalr_link", T_JALR_LINK, 1'b1);
        step("jalr_wb", T_ALUWB, 1'b1);
        set_instr(OP_R, 3'd0, 7'd0);
        for (int i = 0; i < 15; i++)
            step("late_ready_wait", T_FETCH, 1'b0);
        step("late_ready_last", T_FETCH, 1'b1);
        step("late_ready_decode", T_DECODE, 1'b1);
        step("late_ready_exec", T_EXECUTER, 1'b1);
        step("late_ready_wb", T_ALUWB, 1'b1);
        set_instr(7'b0000000, 3'd0, 7'd0);
        step("illegal_fetch", T_FETCH, 1'b1);
        step("illegal_decode", T_DECODE, 1'b1);
        step("illegal_halt0", T_HALT, 1'b1);
        step("illegal_halt1", T_HALT, 1'b1);
        apply_reset("reset_after_halt");
        set_instr(OP_R, 3'd0, 7'd0);
        for (int i = 0; i < 16; i++)
            step("timeout_wait", T_FETCH, 1'b0);
        exp_berr = 1'b1;
        step("timeout_halt0", T_HALT, 1'b1);
        step("timeout_halt1", T_HALT, 1'b0);
        apply_reset("reset_clears_bus_error");
        set_instr(OP_LW, 3'd2, 7'd0);
        step("rst_lw_fetch", T_FETCH, 1'b1);
        step("rst_lw_decode", T_DECODE, 1'b1);
        step("rst_lw_memadr", T_MEMADR, 1'b1);
        step("rst_lw_memread", T_MEMREAD, 1'b0);
        apply_reset("reset_mid_memread");
        set_instr(OP_BEQ, 3'd0, 7'd0);
        step("post_rst_fetch", T_FETCH, 1'b1);
        step("post_rst_decode", T_DECODE, 1'b1);
        step("post_rst_beq", T_BEQ, 1'b1, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
